// File: rtl/i2c_pcf_pkg.sv
// rtl/i2c_pcf_pkg.sv - shared types and constants for the PCF8574T LCD backpack target
package i2c_pcf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_DATA,
    ST_ACK_D,
    ST_IGNORE
  } i2c_state_e;

  localparam int unsigned PCF_RS    = 0;
  localparam int unsigned PCF_RW    = 1;
  localparam int unsigned PCF_E     = 2;
  localparam int unsigned PCF_BL    = 3;
  localparam int unsigned PCF_D_LSB = 4;

  localparam logic [3:0] FS_4BIT_NIB = 4'h2;

endpackage

// File: rtl/i2c_pcf_lcd_target_dec.sv
// rtl/i2c_pcf_lcd_target_dec.sv - HD44780 4-bit bus decoder watching the expander port
// Emits whole bytes on E falling edges; switches to nibble pairing after a 4-bit function set.
module hd44780_nibble_dec
  import i2c_pcf_pkg::*;
#(
  parameter logic E_RST = 1'b1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic [7:0] port_q,
  input  logic       port_stb,
  output logic       lcd_valid,
  output logic [7:0] lcd_byte,
  output logic       lcd_rs,
  output logic       lcd_4bit
);

  logic       e_q, e_d;
  logic       mode4_q, mode4_d;
  logic       half_q, half_d;
  logic [3:0] hi_nib_q, hi_nib_d;
  logic       hi_rs_q, hi_rs_d;
  logic       valid_q, valid_d;
  logic [7:0] byte_q, byte_d;
  logic       rs_q, rs_d;

  logic       e_fall;
  logic [3:0] nib;
  logic       rs_new;
  logic       unused_bits;

  assign e_fall      = port_stb & e_q & ~port_q[PCF_E];
  assign nib         = port_q[PCF_D_LSB +: 4];
  assign rs_new      = port_q[PCF_RS];
  assign unused_bits = ^{port_q[PCF_RW], port_q[PCF_BL]};

  always_comb begin
    e_d      = e_q;
    mode4_d  = mode4_q;
    half_d   = half_q;
    hi_nib_d = hi_nib_q;
    hi_rs_d  = hi_rs_q;
    valid_d  = 1'b0;
    byte_d   = byte_q;
    rs_d     = rs_q;
    if (port_stb) begin
      e_d = port_q[PCF_E];
    end
    if (e_fall) begin
      if (!mode4_q) begin
        valid_d = 1'b1;
        byte_d  = {nib, 4'h0};
        rs_d    = rs_new;
        if (nib == FS_4BIT_NIB && !rs_new) begin
          mode4_d = 1'b1;
          half_d  = 1'b0;
        end
      end else if (!half_q) begin
        hi_nib_d = nib;
        hi_rs_d  = rs_new;
        half_d   = 1'b1;
      end else begin
        valid_d = 1'b1;
        byte_d  = {hi_nib_q, nib};
        rs_d    = hi_rs_q;
        half_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      e_q      <= E_RST;
      mode4_q  <= 1'b0;
      half_q   <= 1'b0;
      hi_nib_q <= 4'h0;
      hi_rs_q  <= 1'b0;
      valid_q  <= 1'b0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
    end else begin
      e_q      <= e_d;
      mode4_q  <= mode4_d;
      half_q   <= half_d;
      hi_nib_q <= hi_nib_d;
      hi_rs_q  <= hi_rs_d;
      valid_q  <= valid_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
    end
  end

  assign lcd_valid = valid_q;
  assign lcd_byte  = byte_q;
  assign lcd_rs    = rs_q;
  assign lcd_4bit  = mode4_q;

endmodule

// File: rtl/i2c_pcf_lcd_target.sv
// rtl/i2c_pcf_lcd_target.sv - oversampled I2C write-only target driving a PCF8574 port
// Reads are NACKed; every ACKed data byte lands on port_q at the end of its ACK slot.
module i2c_pcf_lcd_target
  import i2c_pcf_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h27,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PORT_RST    = 8'hFF
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] port_q,
  output logic       port_stb,
  output logic       lcd_valid,
  output logic [7:0] lcd_byte,
  output logic       lcd_rs,
  output logic       lcd_4bit,
  output logic [7:0] nack_cnt
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       oe_q, oe_d;
  logic [7:0] port_d;
  logic       stb_q, stb_d;
  logic [7:0] nack_q, nack_d;

  // Sync flops reset to the idle-bus level so release of rstb cannot fake an edge
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    oe_d    = oe_q;
    port_d  = port_q;
    stb_d   = 1'b0;
    nack_d  = nack_q;
    if (stop_det) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
    end else if (start_det) begin
      state_d = ST_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (state_q == ST_DATA) begin
                state_d = ST_ACK_D;
              end else if (shift_d[7:1] == DEV_ADDR && !shift_d[0]) begin
                state_d = ST_ACK_A;
              end else begin
                state_d = ST_IGNORE;
                if (nack_q != 8'hFF) nack_d = nack_q + 8'd1;
              end
            end
          end
        end
        // First fall opens the ACK slot, second fall (9th clock) closes it
        ST_ACK_A, ST_ACK_D: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d    = 1'b0;
              state_d = ST_DATA;
              cnt_d   = 3'd0;
              if (state_q == ST_ACK_D) begin
                port_d = shift_q;
                stb_d  = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      oe_q    <= 1'b0;
      port_q  <= PORT_RST;
      stb_q   <= 1'b0;
      nack_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      oe_q    <= oe_d;
      port_q  <= port_d;
      stb_q   <= stb_d;
      nack_q  <= nack_d;
    end
  end

  assign sda_oe   = oe_q;
  assign port_stb = stb_q;
  assign nack_cnt = nack_q;

  hd44780_nibble_dec #(
    .E_RST(PORT_RST[PCF_E])
  ) u_dec (
    .clk      (clk),
    .rstb     (rstb),
    .port_q   (port_q),
    .port_stb (stb_q),
    .lcd_valid(lcd_valid),
    .lcd_byte (lcd_byte),
    .lcd_rs   (lcd_rs),
    .lcd_4bit (lcd_4bit)
  );

endmodule

// File: tb/tb_i2c_pcf_lcd_target.sv
// tb/tb_i2c_pcf_lcd_target.sv - bench for the PCF8574T LCD backpack target
module tb_i2c_pcf_lcd_target;

  localparam time CLK_P = 10;
  localparam time Q     = 40;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;

  logic       sda_oe, port_stb, lcd_valid, lcd_rs, lcd_4bit;
  logic [7:0] port_q, lcd_byte, nack_cnt;

  assign sda_bus = sda_m & ~sda_oe;

  always #(CLK_P/2) clk = ~clk;

  i2c_pcf_lcd_target dut (
    .clk      (clk),
    .rstb     (rstb),
    .scl_i    (scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .port_q   (port_q),
    .port_stb (port_stb),
    .lcd_valid(lcd_valid),
    .lcd_byte (lcd_byte),
    .lcd_rs   (lcd_rs),
    .lcd_4bit (lcd_4bit),
    .nack_cnt (nack_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0] lcd_got[$];
  int         stb_cnt = 0;
  int         oe_cnt = 0;
  always @(negedge clk) begin
    if (lcd_valid) lcd_got.push_back({lcd_rs, lcd_byte});
    if (port_stb) stb_cnt++;
    if (sda_oe) oe_cnt++;
  end

  logic [8:0] lcd_exp[$];
  int         lcd_rd = 0;
  logic       m_e = 1'b1, m_mode4 = 1'b0, m_half = 1'b0, m_hirs = 1'b0;
  logic [3:0] m_hi = 4'h0;
  logic [7:0] m_port = 8'hFF;
  int         m_nack = 0;

  logic [7:0] tx_buf[0:15];
  int         tx_n;

  typedef struct {
    logic [7:0] addr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic [7:0] exp_port;
    logic [7:0] exp_nack;
    int         exp_lcd;
    logic [8:0] exp_last;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour of the LCD decoder: a byte per E fall, or per pair of falls in 4-bit mode
  task automatic model_port(input logic [7:0] v);
    logic [3:0] nib;
    logic       rs;
    nib = v[7:4];
    rs  = v[0];
    if (m_e && !v[2]) begin
      if (!m_mode4) begin
        lcd_exp.push_back({rs, nib, 4'h0});
        if (nib == 4'h2 && !rs) begin
          m_mode4 = 1'b1;
          m_half  = 1'b0;
        end
      end else if (!m_half) begin
        m_hi   = nib;
        m_hirs = rs;
        m_half = 1'b1;
      end else begin
        lcd_exp.push_back({m_hirs, m_hi, nib});
        m_half = 1'b0;
      end
    end
    m_e    = v[2];
    m_port = v;
  endtask

  task automatic compare_lcd(input string nm);
    int got_n;
    got_n = lcd_got.size() - lcd_rd;
    chk({nm, "_lcd_count"}, got_n, lcd_exp.size());
    for (int i = 0; i < got_n && i < lcd_exp.size(); i++)
      chk({nm, "_lcd_event"}, lcd_got[lcd_rd + i], lcd_exp[i]);
    lcd_rd = lcd_got.size();
    lcd_exp.delete();
  endtask

  task automatic bit_io(input logic b, output logic rd);
    #Q sda_m = b;
    #Q scl = 1'b1;
    #Q rd = sda_bus;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic i2c_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], r);
    bit_io(1'b1, r);
    ack = ~r;
  endtask

  task automatic send_txn(input logic [7:0] a);
    logic ack, exp_ack;
    int   stb0, nstb;
    stb0    = stb_cnt;
    nstb    = 0;
    exp_ack = (a[7:1] == 7'h27) && !a[0];
    i2c_start();
    i2c_byte(a, ack);
    chk("addr_ack", ack, exp_ack);
    if (!exp_ack && m_nack != 255) m_nack++;
    for (int i = 0; i < tx_n; i++) begin
      i2c_byte(tx_buf[i], ack);
      chk("data_ack", ack, exp_ack);
      if (exp_ack) begin
        model_port(tx_buf[i]);
        nstb++;
      end
    end
    i2c_stop();
    #(4*CLK_P);
    chk("port_q", port_q, m_port);
    chk("nack_cnt", nack_cnt, m_nack);
    chk("port_stb_count", stb_cnt - stb0, nstb);
  endtask

  initial begin
    logic       r, ack;
    logic [7:0] a;
    int         oe0, lr, stb0;

    vecs[0] = '{8'h4C, 1, 8'h55, 8'h00, 1'b0, 8'hFF, 8'd1, 0, 9'h000};
    vecs[1] = '{8'h4F, 1, 8'hAA, 8'h00, 1'b0, 8'hFF, 8'd2, 0, 9'h000};
    vecs[2] = '{8'h4E, 2, 8'h34, 8'h30, 1'b1, 8'h30, 8'd2, 1, 9'h030};
    vecs[3] = '{8'h4E, 1, 8'h38, 8'h00, 1'b1, 8'h38, 8'd2, 0, 9'h000};

    #(3*CLK_P + 1);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_port_q", port_q, 8'hFF);
    chk("rst_port_stb", port_stb, 1'b0);
    chk("rst_lcd_valid", lcd_valid, 1'b0);
    chk("rst_lcd_byte", lcd_byte, 8'h00);
    chk("rst_lcd_rs", lcd_rs, 1'b0);
    chk("rst_lcd_4bit", lcd_4bit, 1'b0);
    chk("rst_nack_cnt", nack_cnt, 8'h00);
    #(2*CLK_P - 1);
    rstb = 1'b1;
    #(4*CLK_P);

    for (int v = 0; v < 4; v++) begin
      tx_n      = vecs[v].n;
      tx_buf[0] = vecs[v].d0;
      tx_buf[1] = vecs[v].d1;
      oe0       = oe_cnt;
      lr        = lcd_got.size();
      send_txn(vecs[v].addr);
      chk("vec_port", port_q, vecs[v].exp_port);
      chk("vec_nack", nack_cnt, vecs[v].exp_nack);
      chk("vec_lcd_count", lcd_got.size() - lr, vecs[v].exp_lcd);
      if (vecs[v].exp_lcd > 0) chk("vec_lcd_last", lcd_got[lcd_got.size() - 1], vecs[v].exp_last);
      if (!vecs[v].exp_ack) chk("vec_no_drive", oe_cnt - oe0, 0);
      chk("vec_4bit", lcd_4bit, 1'b0);
      compare_lcd("vec");
    end

    // Rest of the init sequence: two more 8-bit 0x3 strobes, then the 4-bit function set
    tx_n = 6;
    tx_buf[0] = 8'h34; tx_buf[1] = 8'h30; tx_buf[2] = 8'h34;
    tx_buf[3] = 8'h30; tx_buf[4] = 8'h24; tx_buf[5] = 8'h20;
    lr = lcd_got.size();
    send_txn(8'h4E);
    chk("init_4bit", lcd_4bit, 1'b1);
    chk("init_count", lcd_got.size() - lr, 3);
    chk("init_last", lcd_got[lcd_got.size() - 1], 9'h020);
    compare_lcd("init");

    tx_n = 6;
    tx_buf[0] = 8'h39; tx_buf[1] = 8'h3D; tx_buf[2] = 8'h39;
    tx_buf[3] = 8'h09; tx_buf[4] = 8'h0D; tx_buf[5] = 8'h09;
    lr = lcd_got.size();
    send_txn(8'h4E);
    chk("nib4_count", lcd_got.size() - lr, 1);
    chk("nib4_byte", lcd_got[lcd_got.size() - 1], 9'h130);
    compare_lcd("nib4");

    // STOP after 4 data bits, then a repeated START mid-byte
    a = 8'h4E;
    stb0 = stb_cnt;
    i2c_start();
    i2c_byte(a, ack);
    chk("partial_addr_ack", ack, 1'b1);
    for (int i = 0; i < 4; i++) bit_io(i[0], r);
    i2c_stop();
    #(4*CLK_P);
    chk("partial_stop_port", port_q, m_port);
    i2c_start();
    i2c_byte(a, ack);
    for (int i = 0; i < 4; i++) bit_io(~i[0], r);
    chk("partial_rs_stb", stb_cnt - stb0, 0);
    tx_n = 1;
    tx_buf[0] = 8'hA5;
    send_txn(8'h4E);
    chk("rs_port_a5", port_q, 8'hA5);
    compare_lcd("rs");

    // Reset while the target is driving the address ACK
    chk("pre_rst_4bit", lcd_4bit, 1'b1);
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_io(a[i], r);
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q chk("ack_driven", sda_oe, 1'b1);
    rstb = 1'b0;
    #1;
    chk("rst_mid_sda_oe", sda_oe, 1'b0);
    chk("rst_mid_port_q", port_q, 8'hFF);
    chk("rst_mid_4bit", lcd_4bit, 1'b0);
    chk("rst_mid_nack", nack_cnt, 8'h00);
    #(Q - 1) scl = 1'b0;
    #Q scl = 1'b1;
    #Q rstb = 1'b1;
    #Q;
    m_e = 1'b1; m_mode4 = 1'b0; m_half = 1'b0; m_port = 8'hFF; m_nack = 0;
    lcd_exp.delete();
    lcd_rd = lcd_got.size();

    // Clocking without a START must leave the target idle
    oe0  = oe_cnt;
    stb0 = stb_cnt;
    scl  = 1'b0;
    for (int i = 0; i < 18; i++) bit_io(1'b0, r);
    i2c_stop();
    #(4*CLK_P);
    chk("idle_no_drive", oe_cnt - oe0, 0);
    chk("idle_no_stb", stb_cnt - stb0, 0);
    chk("idle_port", port_q, 8'hFF);

    for (int t = 0; t < 16; t++) begin
      logic [7:0] ra;
      ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h4E;
      tx_n = $urandom_range(1, 6);
      for (int i = 0; i < tx_n; i++) tx_buf[i] = 8'($urandom);
      send_txn(ra);
      chk("rand_4bit", lcd_4bit, m_mode4);
      compare_lcd("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_pcf_lcd_target.md
Name: i2c_pcf_lcd_target

Overview:
- Synthesizable I2C target model of the PCF8574T LCD backpack: the far end of the LCD display write path.
- Oversamples SCL/SDA with clk, ACKs write transfers to its 7-bit address, and drives an 8-bit expander port.
- Decodes HD44780 4-bit-bus activity on that port (E strobe, RS, D7..D4) into whole instruction/data bytes.
- Used as an on-chip loopback target for bring-up and as the checker-side model in display-path benches.

Parameters:
- DEV_ADDR, 7'h27, I2C target address.
- SYNC_STAGES, 2, synchronizer depth for scl_i/sda_i; legal range 2..3.
- PORT_RST, 8'hFF, port_q value after reset (PCF8574 power-on: all high).

Ports:
- clk  in  1  system clock, at least 8x the SCL rate.
- rstb  in  1  reset, asynchronous, active-low.
- scl_i  in  1  I2C SCL, asynchronous.
- sda_i  in  1  I2C SDA, asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain ACK).
- port_q  out  8  expander port: [0]=RS, [1]=RW, [2]=E, [3]=BL, [7:4]=D7..D4.
- port_stb  out  1  one-cycle pulse when port_q updates.
- lcd_valid  out  1  one-cycle pulse when lcd_byte/lcd_rs are valid.
- lcd_byte  out  8  decoded HD44780 byte.
- lcd_rs  out  1  0 = instruction, 1 = data.
- lcd_4bit  out  1  decoder is in 4-bit pairing mode.
- nack_cnt  out  8  saturating count of NACKed address phases.

Behaviour:
- Reset values: sda_oe=0, port_q=PORT_RST, port_stb=0, lcd_valid=0, lcd_byte=0, lcd_rs=0, lcd_4bit=0, nack_cnt=0. FSM goes to IDLE and the decoder goes to 8-bit mode.
- Reset may assert mid-transfer. Any in-flight byte is discarded and sda_oe is released immediately (asynchronous).
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized values only.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- START, including repeated START, is recognized in any state. It clears the bit counter and enters ADDR.
- STOP in any state returns to IDLE and releases sda_oe.
- FSM states are IDLE, ADDR, ACK_A, DATA, ACK_D, IGNORE.
- ADDR: shift SDA MSB-first on each SCL rise. After the 8th rise:
  - addr==DEV_ADDR and R/W=0: go to ACK_A.
  - Otherwise: go to IGNORE and increment nack_cnt (saturates at 255).
- ACK_A / ACK_D timing:
  - sda_oe asserts on the SCL fall after the 8th bit.
  - sda_oe holds through the 9th clock.
  - sda_oe deasserts on the 9th SCL fall.
- DATA: shift 8 bits. At the 9th SCL fall, which ends ACK_D:
  - port_q <= received byte and port_stb pulses.
  - FSM returns to DATA, so multi-byte writes are supported.
- IGNORE: sda_oe stays 0. Only START or STOP leave this state.
- Read requests (R/W=1) are NACKed. A read is never driven.
- Bus timing: SCL falls outside ACK slots produce no port change. A STOP before the 8th bit discards the partial byte.
- Decoder (sub-module) acts on each port_stb. An E falling edge is old port_q[2]=1 and new port_q[2]=0.
  - On that edge, nibble = new port_q[7:4] and rs = new port_q[0].
- 8-bit mode (lcd_4bit=0):
  - Each E fall emits lcd_byte={nibble,4'h0} and lcd_rs=rs, with lcd_valid pulsing the cycle after port_stb.
  - If nibble==4'h2 and rs=0, set lcd_4bit=1 and clear the half flag.
- 4-bit mode:
  - First E fall stores the high nibble and its rs.
  - Second E fall emits {high,low} with lcd_rs = high-nibble rs.
  - Latency is 1 clk from port_stb.
- 4-bit mode persists until rstb. The decoder ignores a function-set's DL bit once in 4-bit mode.
- Port writes without an E falling edge produce no lcd_valid.

Decomposition:
- Package i2c_pcf_pkg holds:
  - FSM state encoding.
  - Port bit indices: PCF_RS=0, PCF_RW=1, PCF_E=2, PCF_BL=3, PCF_D_LSB=4.
  - HD44780 constant FS_4BIT_NIB=4'h2.
- Sub-module hd44780_nibble_dec: inputs clk, rstb, port_q, port_stb; outputs lcd_valid, lcd_byte, lcd_rs, lcd_4bit.

Test Plan:
- Write to 0x27 with data 0x34, 0x30 -> ACK on both bytes. port_q = 0x34 then 0x30. lcd_valid once with byte 0x30, rs=0, lcd_4bit=0.
- Init sequence: three 8-bit 0x3 strobes, then 0x2 strobe -> three bytes 0x30, then 0x20. lcd_4bit=1 after the 4th strobe.
- In 4-bit mode, write 0x39,0x3D,0x39, 0x09,0x0D,0x09 (nibbles 3,0 with RS) -> a single lcd_valid, byte 0x30, rs=1.
- Address 0x26 write, then 0x27 read -> no ACK on either, sda_oe never 1, nack_cnt=2, port_q unchanged at 0xFF.
- STOP after 4 data bits, then repeated START mid-byte -> port_q unchanged. The next full byte 0xA5 is ACKed and port_q=0xA5.
- rstb asserted while sda_oe=1 during ACK -> sda_oe drops immediately. port_q=0xFF, lcd_4bit=0, FSM in IDLE.
